// File: rtl/bulk_arb_pkg.sv
// rtl/bulk_arb_pkg.sv - shared types and pick logic for the bulk memory arbiter
package bulk_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    // A dumping requester locks the port to itself; m0 wins if both dump.
    function automatic logic [1:0] dump_mask(input logic [1:0] valid, input logic [1:0] dump);
        if (dump[0]) begin
            return valid & 2'b01;
        end else if (dump[1]) begin
            return valid & 2'b10;
        end
        return valid;
    endfunction

    // Round-robin choice among eligible requesters; ties go to whoever was not served last.
    function automatic req_id_t rr_pick(input logic [1:0] valid, input logic [1:0] dump,
                                        input req_id_t last);
        logic [1:0] elig;
        elig = dump_mask(valid, dump);
        if (elig == 2'b11) begin
            return ~last;
        end else if (elig[1]) begin
            return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/bulk_read_interface.sv
// rtl/bulk_read_interface.sv - whole-line read/writeback port between a cache and memory
interface bulk_read_interface #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BYTES = 128
);
    localparam int WORDS_PER_LINE = LINE_BYTES / (DATA_W / 8);
    localparam int LINE_W         = WORDS_PER_LINE * DATA_W;
    localparam int STRB_W         = LINE_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [STRB_W-1:0] req_wstrb;
    logic [LINE_W-1:0] req_wdata;
    logic              resp_valid;
    logic [LINE_W-1:0] resp_rdata;
    logic              dumping_cache;

    modport master (
        output req_valid, req_addr, req_write, req_wstrb, req_wdata, dumping_cache,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wstrb, req_wdata, dumping_cache,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/bulk_memory_arbiter.sv
// rtl/bulk_memory_arbiter.sv - two-requester whole-line arbiter onto one memory port
module bulk_memory_arbiter
    import bulk_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BYTES = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    bulk_read_interface.slave       m0_in,
    bulk_read_interface.slave       m1_in,
    bulk_read_interface.master      mem_out,
    output logic                    owner,
    output logic                    busy,
    output logic                    protocol_err
);

    localparam int WORDS_PER_LINE = LINE_BYTES / (DATA_W / 8);
    localparam int LINE_W         = WORDS_PER_LINE * DATA_W;
    localparam int STRB_W         = LINE_W / 8;

    arb_state_t state_q, state_d;
    req_id_t    owner_q, owner_d;
    req_id_t    last_q, last_d;
    logic       perr_q, perr_d;
    logic       busy_q, busy_d;

    logic [1:0]        valid_v;
    logic [1:0]        dump_v;
    logic              grant_any;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_write;
    logic [STRB_W-1:0] sel_wstrb;
    logic [LINE_W-1:0] sel_wdata;
    logic              in_issue;
    logic              in_wait;

    assign valid_v   = {m1_in.req_valid, m0_in.req_valid};
    assign dump_v    = {m1_in.dumping_cache, m0_in.dumping_cache};
    assign grant_any = |dump_mask(valid_v, dump_v);
    assign in_issue  = (state_q == ISSUE);
    assign in_wait   = (state_q == WAIT_RESP);

    assign sel_valid = owner_q ? m1_in.req_valid : m0_in.req_valid;
    assign sel_addr  = owner_q ? m1_in.req_addr  : m0_in.req_addr;
    assign sel_write = owner_q ? m1_in.req_write : m0_in.req_write;
    assign sel_wstrb = owner_q ? m1_in.req_wstrb : m0_in.req_wstrb;
    assign sel_wdata = owner_q ? m1_in.req_wdata : m0_in.req_wdata;

    // Next-state: grant from IDLE, forward in ISSUE, hold the port until the read line returns.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        perr_d  = perr_q | (mem_out.resp_valid && !in_wait);
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    owner_d = rr_pick(valid_v, dump_v, last_q);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!sel_valid) begin
                    state_d = IDLE;
                end else if (mem_out.req_ready) begin
                    last_d  = owner_q;
                    state_d = sel_write ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_out.resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and status registers; reset abandons any outstanding grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
        end
    end

    // Memory-side request is the owner's request in ISSUE and all-zero otherwise.
    always_comb begin
        mem_out.req_valid = 1'b0;
        mem_out.req_addr  = '0;
        mem_out.req_write = 1'b0;
        mem_out.req_wstrb = '0;
        mem_out.req_wdata = '0;
        if (in_issue) begin
            mem_out.req_valid = sel_valid;
            mem_out.req_addr  = sel_addr;
            mem_out.req_write = sel_write;
            mem_out.req_wstrb = sel_wstrb;
            mem_out.req_wdata = sel_wdata;
        end
    end

    assign mem_out.dumping_cache = m0_in.dumping_cache | m1_in.dumping_cache;

    assign m0_in.req_ready  = in_issue && !owner_q && m0_in.req_valid && mem_out.req_ready;
    assign m1_in.req_ready  = in_issue &&  owner_q && m1_in.req_valid && mem_out.req_ready;
    assign m0_in.resp_valid = in_wait  && !owner_q && mem_out.resp_valid;
    assign m1_in.resp_valid = in_wait  &&  owner_q && mem_out.resp_valid;
    assign m0_in.resp_rdata = mem_out.resp_rdata;
    assign m1_in.resp_rdata = mem_out.resp_rdata;

    assign owner        = owner_q;
    assign busy         = busy_q;
    assign protocol_err = perr_q;

endmodule

// File: doc/bulk_memory_arbiter.md
# bulk_memory_arbiter

Two-requester arbiter that shares one `bulk_read_interface` backing-memory port between two line caches, for example the instruction and data `bulk_read_interface` masters. It sits between the caches' `memory_access_out` ports and the memory controller. It serialises whole-line reads and writebacks. It never interleaves a read's request and response with another requester's traffic. It keeps a cache dump contiguous.

## Interface
- `ADDR_W`, default 64: request address width.
- `DATA_W`, default 64: word width.
- `LINE_BYTES`, default 128: bytes per line. `WORDS_PER_LINE = LINE_BYTES/(DATA_W/8)`.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset. Synchronous, active-high.
- `m0_in`, `bulk_read_interface.slave`, line: requester 0, higher tie priority after reset.
- `m1_in`, `bulk_read_interface.slave`, line: requester 1.
- `mem_out`, `bulk_read_interface.master`, line: shared memory port.
- `owner`, output, 1: index of the current or most recent grantee.
- `busy`, output, 1: high in any state except `IDLE`.
- `protocol_err`, output, 1: sticky. Set by `mem_out.resp_valid` arriving outside `WAIT_RESP`.

## Operation
- States:
  - `IDLE`: no grant.
  - `ISSUE`: the grantee's request is forwarded to `mem_out`.
  - `WAIT_RESP`: a read was accepted; waiting for its line.
- `IDLE`, arbitration:
  - If exactly one `req_valid` is high, grant it.
  - If both are high, grant the requester not equal to `last_served`.
  - Dump lock: if `mX.dumping_cache` is high, only `mX` may be granted. If both requesters assert it, `m0` wins.
  - On a grant: register `owner`, go to `ISSUE`.
- `ISSUE`:
  - `mem_out.req_valid/addr/write/wstrb/wdata` are driven combinationally from the owner.
  - The owner's `req_ready = mem_out.req_ready`.
  - On the handshake (`mem_out.req_valid && mem_out.req_ready`), set `last_served <= owner`.
  - After the handshake, go to `WAIT_RESP` if `req_write == 0`, otherwise go to `IDLE`.
  - If the owner drops `req_valid` before the handshake, return to `IDLE` with no transfer. `last_served` is unchanged.
- `WAIT_RESP`:
  - The owner's `resp_valid = mem_out.resp_valid`.
  - On `resp_valid`, go to `IDLE`.
- Routing:
  - `resp_rdata` is broadcast to both requesters.
  - The non-owner always sees `req_ready = 0` and `resp_valid = 0`, in every state.
  - `mem_out.dumping_cache = m0_in.dumping_cache | m1_in.dumping_cache`.
- `mem_out` drive when not in `ISSUE`: `req_valid = 0`, `req_write = 0`, all other `req_*` fields 0.

## Timing
- Reset values:
  - State: `IDLE`, `owner = 0`, `last_served = 1`, `protocol_err = 0`, `busy = 0`.
  - All `req_ready`, all `resp_valid`, `mem_out.req_valid`: 0.
- Reset mid-transaction:
  - Any outstanding grant is abandoned.
  - A memory response that arrives later sets `protocol_err`.
- Arbitration latency:
  - One cycle. A request seen in `IDLE` at cycle N is presented on `mem_out` at N+1.
  - Best-case read: N+1 handshake, then `resp_valid` at N+1+L, with L the memory latency.
  - Best-case write: the handshake at N+1 frees the port; `IDLE` at N+2.
- No combinational path from `mX.req_valid` to `mem_out.req_valid` while in `IDLE`. The grant is registered.
- Handshake rule: a requester must hold `req_valid` and its fields stable until it sees `req_ready`. The arbiter never asserts `req_ready` to a requester not holding `req_valid`.
- A simultaneous new request from the other master during `WAIT_RESP` waits. It is granted in the `IDLE` cycle that follows `resp_valid`, because it is not `last_served`.
- Fairness: with both requesting continuously and no dump lock, grants strictly alternate.
- Dump lock is evaluated only in `IDLE`. It does not pre-empt an in-flight transaction.

## Structure
- Shared package `bulk_arb_pkg` holds:
  - `arb_state_t` enum: `IDLE`, `ISSUE`, `WAIT_RESP`.
  - `req_id_t` typedef: 1 bit.
  - Function `rr_pick(valid[1:0], dump[1:0], last)` returning `req_id_t`.
- No sub-module. The block is one FSM plus a registered mux.

## Test plan
1. Reset then idle → all `req_ready`/`resp_valid` are 0, `busy = 0`, `owner = 0`, `mem_out.req_valid = 0`.
2. `m0` reads `0x1000`; memory `req_ready` at once, `resp_valid` 3 cycles later with word0 `0xDEAD` → `m0` gets `req_ready` at cycle 1 and `resp_valid` at cycle 4; `m1.resp_valid` stays 0.
3. `m0` and `m1` both read in the same cycle after reset → `m0` is served first, then `m1` (grant in the `IDLE` cycle after `m0`'s `resp_valid`); with continuous requests, `owner` alternates 0,1,0,1.
4. `m1` writeback to `0x2080` with full `wstrb` while `m0` reads → the write handshake returns the arbiter to `IDLE` without waiting for a response; `m0` is then granted next.
5. `m1.dumping_cache = 1` issuing 3 writebacks while `m0` requests → all 3 `m1` writes complete before `m0` is granted; `mem_out.dumping_cache = 1` throughout.
6. `mem_out.resp_valid` pulsed in `IDLE` → `protocol_err = 1` and stays 1 until `rst`; no requester sees `resp_valid`.
